// File: rtl/axi_wr_pkg.sv
// Shared AXI write-responder codes, FSM state type and burst-type decode.
package axi_wr_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        RESP
    } wr_state_t;

    // WRAP and the reserved encoding are accepted on AW but never written.
    function automatic logic [1:0] burst_resp(input logic [1:0] burst);
        if (burst == BURST_WRAP || burst == 2'd3)
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_wr_bram.sv
// Byte-enabled single-write-port RAM with a registered read-first debug read port.
module axi_wr_bram #(
    parameter  int DATA_WIDTH = 32,
    parameter  int MEM_DEPTH  = 256,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int PTR_WIDTH  = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  we,
    input  logic [PTR_WIDTH-1:0]  waddr,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PTR_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wstrb[b])
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Non-blocking read of the array gives the pre-write word on a same-address collision.
    always_ff @(posedge clk) begin
        if (areset)
            rdata <= '0;
        else
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi_wr_responder.sv
// AXI write-channel slave: one burst at a time, beats stored in an internal RAM, one B per burst.
// Optional macro AXI_WR_STALL_EN toggles s_wready_o every DATA cycle for W backpressure.
module axi_wr_responder
    import axi_wr_pkg::*;
#(
    parameter  int                    DATA_WIDTH = 32,
    parameter  int                    ADDR_WIDTH = 64,
    parameter  int                    MEM_DEPTH  = 256,
    parameter  logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    localparam int                    STRB_WIDTH = DATA_WIDTH / 8,
    localparam int                    PTR_WIDTH  = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [3:0]            s_awid_i,
    input  logic [ADDR_WIDTH-1:0] s_awaddr_i,
    input  logic [1:0]            s_awburst_i,
    input  logic                  s_awvalid_i,
    output logic                  s_awready_o,
    input  logic [3:0]            s_wid_i,
    input  logic [DATA_WIDTH-1:0] s_wdata_i,
    input  logic [STRB_WIDTH-1:0] s_wstrb_i,
    input  logic                  s_wlast_i,
    input  logic                  s_wvalid_i,
    output logic                  s_wready_o,
    output logic [3:0]            s_bid_o,
    output logic [1:0]            s_bresp_o,
    output logic                  s_bvalid_o,
    input  logic                  s_bready_i,
    input  logic [PTR_WIDTH-1:0]  dbg_raddr_i,
    output logic [DATA_WIDTH-1:0] dbg_rdata_o
);

    localparam int                    BYTE_SHIFT = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(MEM_DEPTH);

    wr_state_t             state;
    logic [3:0]            cur_id;
    logic [1:0]            cur_burst;
    logic [PTR_WIDTH-1:0]  cur_ptr;
    logic [1:0]            cur_err;

    logic [ADDR_WIDTH-1:0] aw_offset;
    logic [ADDR_WIDTH-1:0] aw_word;
    logic [1:0]            aw_err;
    logic                  w_beat;
    logic                  id_match;
    logic                  mem_we;

    // Address decode of the incoming AW; only consumed on the accepting cycle.
    always_comb begin
        aw_offset = s_awaddr_i - BASE_ADDR;
        aw_word   = aw_offset >> BYTE_SHIFT;
        if (s_awaddr_i < BASE_ADDR || aw_word >= DEPTH_A)
            aw_err = RESP_DECERR;
        else
            aw_err = burst_resp(s_awburst_i);
    end

    assign w_beat   = (state == DATA) && s_wvalid_i && s_wready_o;
    assign id_match = (s_wid_i == cur_id);
    assign mem_we   = w_beat && id_match && (cur_err == RESP_OKAY);

    always_ff @(posedge clk) begin
        if (areset) begin
            state       <= IDLE;
            s_awready_o <= 1'b0;
            s_wready_o  <= 1'b0;
            s_bvalid_o  <= 1'b0;
            s_bid_o     <= '0;
            s_bresp_o   <= RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    s_awready_o <= 1'b1;
                    if (s_awvalid_i && s_awready_o) begin
                        cur_id      <= s_awid_i;
                        cur_burst   <= s_awburst_i;
                        cur_ptr     <= aw_word[PTR_WIDTH-1:0];
                        cur_err     <= aw_err;
                        s_awready_o <= 1'b0;
                        s_wready_o  <= 1'b1;
                        state       <= DATA;
                    end
                end

                DATA: begin
                    if (w_beat) begin
                        if (!id_match)
                            cur_err <= RESP_SLVERR;
                        if (cur_burst == BURST_INCR)
                            cur_ptr <= cur_ptr + 1'b1;
                    end
                    if (w_beat && s_wlast_i) begin
                        s_wready_o <= 1'b0;
                        s_bvalid_o <= 1'b1;
                        s_bid_o    <= cur_id;
                        s_bresp_o  <= id_match ? cur_err : RESP_SLVERR;
                        state      <= RESP;
                    end else begin
`ifdef AXI_WR_STALL_EN
                        s_wready_o <= ~s_wready_o;
`else
                        s_wready_o <= 1'b1;
`endif
                    end
                end

                RESP: begin
                    if (s_bready_i) begin
                        s_bvalid_o  <= 1'b0;
                        s_awready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    axi_wr_bram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_bram (
        .clk    (clk),
        .areset (areset),
        .we     (mem_we),
        .waddr  (cur_ptr),
        .wstrb  (s_wstrb_i),
        .wdata  (s_wdata_i),
        .raddr  (dbg_raddr_i),
        .rdata  (dbg_rdata_o)
    );

endmodule

// File: tb/tb_axi_wr_responder.sv
// Self-checking bench for axi_wr_responder: directed vector table, hand sequences, randomized bursts.
`timescale 1ns/1ps
module tb_axi_wr_responder;
    import axi_wr_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 64;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          areset = 1'b1;
    logic [3:0]    s_awid_i = '0;
    logic [AW-1:0] s_awaddr_i = '0;
    logic [1:0]    s_awburst_i = '0;
    logic          s_awvalid_i = 1'b0;
    logic          s_awready_o;
    logic [3:0]    s_wid_i = '0;
    logic [DW-1:0] s_wdata_i = '0;
    logic [3:0]    s_wstrb_i = '0;
    logic          s_wlast_i = 1'b0;
    logic          s_wvalid_i = 1'b0;
    logic          s_wready_o;
    logic [3:0]    s_bid_o;
    logic [1:0]    s_bresp_o;
    logic          s_bvalid_o;
    logic          s_bready_i = 1'b0;
    logic [7:0]    dbg_raddr_i = '0;
    logic [DW-1:0] dbg_rdata_o;

    axi_wr_responder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MEM_DEPTH  (DEPTH),
        .BASE_ADDR  (64'h0)
    ) dut (
        .clk         (clk),
        .areset      (areset),
        .s_awid_i    (s_awid_i),
        .s_awaddr_i  (s_awaddr_i),
        .s_awburst_i (s_awburst_i),
        .s_awvalid_i (s_awvalid_i),
        .s_awready_o (s_awready_o),
        .s_wid_i     (s_wid_i),
        .s_wdata_i   (s_wdata_i),
        .s_wstrb_i   (s_wstrb_i),
        .s_wlast_i   (s_wlast_i),
        .s_wvalid_i  (s_wvalid_i),
        .s_wready_o  (s_wready_o),
        .s_bid_o     (s_bid_o),
        .s_bresp_o   (s_bresp_o),
        .s_bvalid_o  (s_bvalid_o),
        .s_bready_i  (s_bready_i),
        .dbg_raddr_i (dbg_raddr_i),
        .dbg_rdata_o (dbg_rdata_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] bdata [256];
    logic [3:0]  bstrb [256];
    logic [3:0]  bwid  [256];
    logic [31:0] last_beat_rdata;

    typedef struct {
        logic [3:0]  awid;
        logic [63:0] addr;
        logic [1:0]  btype;
        int          n;
        logic [31:0] dbase;
        int          bad_beat;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout waiting on handshake", name);
    endtask

    // Reference: response from the address/burst rules, then beat-by-beat byte writes.
    task automatic model_apply(input logic [3:0] awid, input logic [63:0] addr, input logic [1:0] btype,
                               input int n, output logic [1:0] resp);
        logic [1:0] err;
        longint unsigned word;
        int w;
        word = addr / 4;
        if (addr >= 64'(DEPTH * 4))      err = RESP_DECERR;
        else if (btype >= 2'd2)          err = RESP_SLVERR;
        else                             err = RESP_OKAY;
        for (int i = 0; i < n; i++) begin
            if (err == RESP_OKAY && bwid[i] == awid) begin
                w = int'((word + ((btype == BURST_INCR) ? longint'(i) : 0)) % DEPTH);
                for (int b = 0; b < 4; b++)
                    if (bstrb[i][b]) model_mem[w][b*8 +: 8] = bdata[i][b*8 +: 8];
            end
            if (bwid[i] != awid) err = RESP_SLVERR;
        end
        resp = err;
    endtask

    // exp_sel[2]=1 means take the expected response from the reference model.
    task automatic do_burst(input string name, input logic [3:0] awid, input logic [63:0] addr,
                            input logic [1:0] btype, input int n, input logic [2:0] exp_sel, input int bdelay);
        int t;
        logic [1:0] mresp;
        logic [1:0] exp_resp;
        model_apply(awid, addr, btype, n, mresp);
        exp_resp = exp_sel[2] ? mresp : exp_sel[1:0];

        s_awid_i = awid; s_awaddr_i = addr; s_awburst_i = btype; s_awvalid_i = 1'b1;
        t = 0;
        while (!s_awready_o && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) begin s_awvalid_i = 1'b0; timeout_fail({name, "_aw"}); return; end
        @(posedge clk); #1;
        s_awvalid_i = 1'b0;

        for (int i = 0; i < n; i++) begin
            s_wid_i = bwid[i]; s_wdata_i = bdata[i]; s_wstrb_i = bstrb[i];
            s_wlast_i = (i == n - 1); s_wvalid_i = 1'b1;
            t = 0;
            while (!s_wready_o && t < 50) begin @(posedge clk); #1; t++; end
            if (t >= 50) begin s_wvalid_i = 1'b0; s_wlast_i = 1'b0; timeout_fail({name, "_w"}); return; end
            @(posedge clk); #1;
            last_beat_rdata = dbg_rdata_o;
        end
        s_wvalid_i = 1'b0; s_wlast_i = 1'b0;

        check({name, "_bvalid"}, s_bvalid_o, 1'b1);
        check({name, "_bid"}, s_bid_o, awid);
        check({name, "_bresp"}, s_bresp_o, exp_resp);
        for (int k = 0; k < bdelay; k++) begin
            @(posedge clk); #1;
            check({name, "_hold_bvalid"}, s_bvalid_o, 1'b1);
            check({name, "_hold_bid"}, s_bid_o, awid);
            check({name, "_hold_bresp"}, s_bresp_o, exp_resp);
            check({name, "_hold_awready"}, s_awready_o, 1'b0);
        end
        s_bready_i = 1'b1;
        @(posedge clk); #1;
        s_bready_i = 1'b0;
        check({name, "_bdone"}, s_bvalid_o, 1'b0);
        check({name, "_awready_back"}, s_awready_o, 1'b1);
    endtask

    task automatic read_ram(input int w, output logic [31:0] val);
        dbg_raddr_i = 8'(w);
        @(posedge clk); #1;
        val = dbg_rdata_o;
    endtask

    task automatic fill_beats(input logic [3:0] awid, input int n, input logic [31:0] dbase, input int bad_beat);
        for (int i = 0; i < n; i++) begin
            bdata[i] = dbase + 32'(i);
            bstrb[i] = 4'hF;
            bwid[i]  = (i == bad_beat) ? (awid ^ 4'h6) : awid;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  dummy;
        logic [3:0]  rid;
        logic [63:0] raddr;
        logic [1:0]  rtype;
        int          rn, bad;

        vecs[0] = '{4'd3, 64'h10,  BURST_INCR,  4, 32'hA0,       -1, RESP_OKAY};
        vecs[1] = '{4'd1, 64'h400, BURST_INCR,  2, 32'hDEAD0000, -1, RESP_DECERR};
        vecs[2] = '{4'd2, 64'h20,  BURST_WRAP,  2, 32'hB0,       -1, RESP_SLVERR};
        vecs[3] = '{4'd3, 64'h30,  BURST_INCR,  3, 32'hC0,        1, RESP_SLVERR};
        vecs[4] = '{4'd4, 64'h40,  2'd3,        1, 32'hD0,       -1, RESP_SLVERR};
        vecs[5] = '{4'd6, 64'h3FC, BURST_INCR,  2, 32'hE0,       -1, RESP_OKAY};
        vecs[6] = '{4'd7, 64'h24,  BURST_FIXED, 3, 32'hF0,       -1, RESP_OKAY};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", s_awready_o, 1'b0);
        check("rst_wready", s_wready_o, 1'b0);
        check("rst_bvalid", s_bvalid_o, 1'b0);
        check("rst_bid", s_bid_o, 4'd0);
        check("rst_bresp", s_bresp_o, 2'd0);
        check("rst_dbg_rdata", dbg_rdata_o, 32'd0);
        areset = 1'b0;
        @(posedge clk); #1;
        check("rel_awready", s_awready_o, 1'b1);

        // Give the whole RAM a known value
        for (int i = 0; i < 256; i++) begin bdata[i] = 32'd0; bstrb[i] = 4'hF; bwid[i] = 4'd0; end
        do_burst("init", 4'd0, 64'h0, BURST_INCR, 256, 3'b000, 0);

        for (int v = 0; v < 7; v++) begin
            fill_beats(vecs[v].awid, vecs[v].n, vecs[v].dbase, vecs[v].bad_beat);
            do_burst($sformatf("vec%0d", v), vecs[v].awid, vecs[v].addr, vecs[v].btype,
                     vecs[v].n, {1'b0, vecs[v].exp_resp}, 0);
        end

        for (int i = 0; i < 4; i++) begin
            read_ram(4 + i, rd);
            check($sformatf("incr_ram%0d", 4 + i), rd, 32'hA0 + 32'(i));
        end
        read_ram(8, rd);   check("wrapburst_nowrite", rd, 32'h0);
        read_ram(12, rd);  check("widerr_beat0", rd, 32'hC0);
        read_ram(13, rd);  check("widerr_beat1_blocked", rd, 32'h0);
        read_ram(255, rd); check("ptrwrap_255", rd, 32'hE0);
        read_ram(0, rd);   check("ptrwrap_0", rd, 32'hE1);
        read_ram(9, rd);   check("fixed_ram9", rd, 32'hF2);
        read_ram(10, rd);  check("fixed_ram10", rd, 32'h0);

        // Strobes plus read-first collision on the debug port
        bdata[0] = 32'hFFFFFFFF; bstrb[0] = 4'hF; bwid[0] = 4'd1;
        do_burst("strb_pre", 4'd1, 64'h8, BURST_INCR, 1, 3'b000, 0);
        dbg_raddr_i = 8'd2;
        bdata[0] = 32'h12345678; bstrb[0] = 4'b0101; bwid[0] = 4'd1;
        do_burst("strb", 4'd1, 64'h8, BURST_INCR, 1, 3'b000, 0);
        check("read_first", last_beat_rdata, 32'hFFFFFFFF);
        read_ram(2, rd);
        check("strb_ram2", rd, 32'hFF34FF78);

        // bready held low for 5 cycles
        fill_beats(4'd9, 2, 32'h77, -1);
        do_burst("bhold", 4'd9, 64'h60, BURST_INCR, 2, 3'b000, 5);

        // Reset after beat 2 of 4: no B, beats already written stay
        fill_beats(4'd2, 2, 32'h5A0, -1);
        model_apply(4'd2, 64'h80, BURST_INCR, 2, dummy);
        s_awid_i = 4'd2; s_awaddr_i = 64'h80; s_awburst_i = BURST_INCR; s_awvalid_i = 1'b1;
        @(posedge clk); #1;
        s_awvalid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_wid_i = 4'd2; s_wdata_i = bdata[i]; s_wstrb_i = 4'hF; s_wlast_i = 1'b0; s_wvalid_i = 1'b1;
            @(posedge clk); #1;
        end
        s_wvalid_i = 1'b0;
        areset = 1'b1;
        @(posedge clk); #1;
        check("midrst_bvalid", s_bvalid_o, 1'b0);
        check("midrst_wready", s_wready_o, 1'b0);
        check("midrst_awready", s_awready_o, 1'b0);
        areset = 1'b0;
        @(posedge clk); #1;
        check("midrst_rel_awready", s_awready_o, 1'b1);
        check("midrst_rel_bvalid", s_bvalid_o, 1'b0);
        read_ram(32, rd); check("midrst_ram32", rd, 32'h5A0);
        read_ram(33, rd); check("midrst_ram33", rd, 32'h5A1);

        // Randomized bursts against the reference model
        for (int r = 0; r < 25; r++) begin
            rid = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0)
                raddr = 64'h400 + 64'($urandom_range(0, 1023)) * 4;
            else
                raddr = 64'($urandom_range(0, 255)) * 4;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: rtype = BURST_INCR;
                6, 7:             rtype = BURST_FIXED;
                8:                rtype = BURST_WRAP;
                default:          rtype = 2'd3;
            endcase
            rn  = $urandom_range(1, 6);
            bad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, rn - 1)) : -1;
            for (int i = 0; i < rn; i++) begin
                bdata[i] = $urandom;
                bstrb[i] = 4'($urandom_range(0, 15));
                bwid[i]  = (i == bad) ? (rid ^ 4'h6) : rid;
            end
            do_burst($sformatf("rand%0d", r), rid, raddr, rtype, rn, 3'b100, $urandom_range(0, 3));
        end

        for (int w = 0; w < DEPTH; w++) begin
            read_ram(w, rd);
            check($sformatf("sweep_ram%0d", w), rd, model_mem[w]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
